rr_port_arbiter: RTL
====================

Name: rr_port_arbiter

Overview:
- Four-requester round-robin arbiter that shares one datapath resource, such as a memory or bus port, between four pipeline clients.
- Drives the 2-bit select of the 4:1 width-parameterised input mux in front of that resource, plus a one-hot grant back to the requesters.
- Holds each grant until the resource signals completion, the requester aborts, or a watchdog timeout fires.
- Sits between the requesting stages and the shared resource's input mux.

Parameters:
- TIMEOUT, 16: cycles a grant may remain in GRANT without done before forced release; 0 disables the watchdog.
- TO_W, 5: width of the watchdog counter; must satisfy 2^TO_W > TIMEOUT.

Ports:
- clk  input  1  single system clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset; clears all state immediately on assertion.
- req  input  4  level request per requester; bit i = requester i.
- done  input  1  one-cycle completion pulse from the shared resource for the current grant.
- gnt  output  4  one-hot grant, registered; 0 when idle.
- sel  output  2  registered mux select = index of granted requester; holds its last value when idle.
- busy  output  1  1 while in GRANT.
- timeout  output  1  one-cycle registered pulse when the watchdog forces a release.

Behaviour:
- Reset values (async, rst_n=0): state=IDLE, gnt=0, sel=0, busy=0, timeout=0, ptr=0, cnt=0.
- Internal state:
  - 2-bit round-robin pointer ptr.
  - Watchdog counter cnt[TO_W-1:0].
  - States IDLE and GRANT.
- Winner selection (combinational), using the req value sampled on the current edge:
  - Winner = first i with req[i]=1, scanning ptr, ptr+1, ptr+2, ptr+3 mod 4 (2-bit wrap, 3+1=0).
- IDLE:
  - If req != 0: next edge sel<=winner, gnt<=1<<winner, busy<=1, cnt<=0, go to GRANT.
  - Latency: gnt and sel are valid the cycle after req is first seen high.
  - If req == 0: stay in IDLE; outputs hold.
- GRANT, release conditions in priority order:
  1. done=1: normal release.
  2. req[sel]=0: abort; release without error.
  3. TIMEOUT!=0 and cnt==TIMEOUT-1: forced release; timeout<=1 for exactly one cycle.
  4. Otherwise: cnt<=cnt+1 and remain in GRANT.
- On any release:
  - ptr<=sel+1 (2-bit wrap).
  - Re-arbitrate on the same edge using the current req with pointer sel+1. The current requester is considered last, so a still-asserted req[sel] is re-granted only if no other bit is set.
  - If a winner exists: load the new sel/gnt, cnt<=0, stay in GRANT. Back-to-back handoff has no bubble cycle.
  - If no winner: gnt<=0, busy<=0, go to IDLE.
- Simultaneous events:
  - done and the timeout condition in the same cycle: done wins, no timeout pulse.
  - done and req[sel] dropping in the same cycle: normal release.
- done while in IDLE: ignored, no state change.
- Invariants: gnt is always 0 or one-hot, and gnt==1<<sel whenever busy=1.
- cnt does not advance in IDLE. It never exceeds TIMEOUT-1 when the watchdog is enabled.
- Reset mid-grant: outputs clear asynchronously. After rst_n deassertion, arbitration restarts from ptr=0 on the next edge with req != 0.
- Fairness: with all four requesting continuously, each requester is granted once per four grants.

Test Plan:
1. Single requester:
   - Reset, then req=4'b0100.
   - Next cycle gnt=4'b0100, sel=2, busy=1.
   - Pulse done, with req still 4'b0100 (only bit 2 set): gnt stays 4'b0100, sel=2, busy=1 (re-granted).
   - Drop req to 0: one cycle later gnt=0, busy=0, sel stays 2.
2. Round-robin rotation:
   - req=4'b1111 held, done pulsed one cycle after each new grant.
   - sel sequence 0,1,2,3,0 with no idle cycles between grants.
3. Pointer skip:
   - After a grant to 1 completes, req=4'b0011.
   - Next grant goes to 0 (scan order 2,3,0,1), not 1.
4. Watchdog:
   - TIMEOUT=4; req=4'b0001, done never asserted.
   - timeout=1 exactly one cycle after 4 cycles in GRANT.
   - Grant re-issues to 0 if req[0] is still the only request. No timeout pulse if done is asserted on cycle 4 instead.
5. Abort and reset mid-grant:
   - req[3] dropped during its grant: release next edge with timeout=0.
   - rst_n pulsed low while gnt=4'b1000: gnt=0, sel=0, busy=0 immediately, without waiting for a clock edge.
   - After rst_n release with req=4'b1010: grant goes to 1.

Source files
------------

// File: rtl/rr_port_arbiter.sv
// Four-requester round-robin arbiter for a shared resource port. It holds each
// grant until done, requester abort, or watchdog expiry, then hands off without a bubble.
module rr_port_arbiter #(
  parameter int TIMEOUT = 16,
  parameter int TO_W    = 5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  input  logic       done,
  output logic [3:0] gnt,
  output logic [1:0] sel,
  output logic       busy,
  output logic       timeout
);

  typedef enum logic {IDLE, GRANT} state_t;

  localparam bit              WD_EN     = (TIMEOUT != 0);
  localparam int              TO_LAST_I = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
  localparam logic [TO_W-1:0] TO_LAST   = TO_LAST_I[TO_W-1:0];

  state_t          state;
  logic [1:0]      ptr;
  logic [TO_W-1:0] cnt;

  logic [2:0] win_idle;
  logic [2:0] win_rel;
  logic [1:0] ptr_rel;
  logic       wd_hit;
  logic       rel;
  logic       to_fire;

  // Returns {found, index}; scans p, p+1, p+2, p+3 with 2-bit wrap.
  function automatic logic [2:0] pick(input logic [3:0] r, input logic [1:0] p);
    logic [2:0] res;
    logic [1:0] idx;
    res = 3'b000;
    for (int k = 3; k >= 0; k--) begin
      idx = p + 2'(k);
      if (r[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

  always_comb begin
    ptr_rel  = sel + 2'd1;
    win_idle = pick(req, ptr);
    win_rel  = pick(req, ptr_rel);
    wd_hit   = WD_EN && (cnt == TO_LAST);
    rel      = done || !req[sel] || wd_hit;
    to_fire  = wd_hit && !done && req[sel];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      gnt     <= 4'b0000;
      sel     <= 2'd0;
      busy    <= 1'b0;
      timeout <= 1'b0;
      ptr     <= 2'd0;
      cnt     <= '0;
    end else begin
      timeout <= 1'b0;
      case (state)
        IDLE: begin
          if (win_idle[2]) begin
            sel   <= win_idle[1:0];
            gnt   <= 4'b0001 << win_idle[1:0];
            busy  <= 1'b1;
            cnt   <= '0;
            state <= GRANT;
          end
        end
        GRANT: begin
          if (rel) begin
            // Current owner rotates to last place so others get the next turn.
            ptr     <= ptr_rel;
            timeout <= to_fire;
            if (win_rel[2]) begin
              sel <= win_rel[1:0];
              gnt <= 4'b0001 << win_rel[1:0];
              cnt <= '0;
            end else begin
              gnt   <= 4'b0000;
              busy  <= 1'b0;
              state <= IDLE;
            end
          end else begin
            cnt <= cnt + TO_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
